// File: rtl/mult_div_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// shift_type encodings and default iteration counts.
package mult_div_seq_pkg;

  localparam int MUL_ITERS_DEFAULT    = 17;
  localparam int DIV_ITERS_DEFAULT    = 32;
  localparam int DIV_PRESHIFT_DEFAULT = 3;

  localparam logic [1:0] SHIFT_RIGHT2       = 2'b00;
  localparam logic [1:0] SHIFT_LEFT_RESTORE = 2'b01;
  localparam logic [1:0] SHIFT_LEFT0        = 2'b10;
  localparam logic [1:0] SHIFT_LEFT1        = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    DPRE = 3'd3,
    DSUB = 3'd4,
    DSHF = 3'd5,
    DONE = 3'd6
  } state_t;

  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_seq_if.sv
// Bus between the sequencer and its requester / 68-bit result register.
interface mult_div_seq_if;
  logic        start;
  logic        op;
  logic        signed_op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [33:0] product_top;
  logic [1:0]  product_low;
  logic [33:0] multiplier_dividen;
  logic [33:0] result_of_add;
  logic        init_we;
  logic        we;
  logic        we_sub;
  logic        shift;
  logic [1:0]  shift_type;
  logic        busy;
  logic        done;
  logic        neg_quot;
  logic        neg_rem;

  modport master (
    output start, op, signed_op, operand_a, operand_b, product_top, product_low,
    input  multiplier_dividen, result_of_add, init_we, we, we_sub, shift,
           shift_type, busy, done, neg_quot, neg_rem
  );

  modport slave (
    input  start, op, signed_op, operand_a, operand_b, product_top, product_low,
    output multiplier_dividen, result_of_add, init_we, we, we_sub, shift,
           shift_type, busy, done, neg_quot, neg_rem
  );
endinterface

// File: rtl/mult_div_booth_enc.sv
// Radix-4 Booth recoder: 3-bit group to {zero, neg, two}.
module mult_div_booth_enc (
  input  logic [2:0] group,
  output logic       zero,
  output logic       neg,
  output logic       two
);

  // Digit decode
  always_comb begin
    zero = 1'b0;
    neg  = 1'b0;
    two  = 1'b0;
    case (group)
      3'b000, 3'b111: zero = 1'b1;
      3'b001, 3'b010: zero = 1'b0;
      3'b011:         two  = 1'b1;
      3'b100: begin
        neg = 1'b1;
        two = 1'b1;
      end
      3'b101, 3'b110: neg  = 1'b1;
      default:        zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/mult_div_seq.sv
// Sequencer and 34-bit adder for the iterative multiply/divide unit.
// Optional signed divide is enabled by defining MULT_DIV_SIGNED_DIV_EN.
module mult_div_seq
  import mult_div_seq_pkg::*;
#(
  parameter int MUL_ITERS    = MUL_ITERS_DEFAULT,
  parameter int DIV_ITERS    = DIV_ITERS_DEFAULT,
  parameter int DIV_PRESHIFT = DIV_PRESHIFT_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  mult_div_seq_if.slave bus
);

  state_t      state, state_nx;
  logic [5:0]  cnt, cnt_nx;
  logic        qbit, qbit_nx;
  logic        booth_prev, booth_prev_nx;
  logic        op_r, sgn_r;
  logic [31:0] a_r, b_r;
  logic        neg_quot_r, neg_rem_r;

  logic [33:0] ext_a, ext_b, div_a, div_b, mag, addend, sum;
  logic        cin;
  logic        b_zero, b_neg, b_two;

  assign ext_a = sgn_r ? {{2{a_r[31]}}, a_r} : {2'b00, a_r};
  assign ext_b = sgn_r ? {{2{b_r[31]}}, b_r} : {2'b00, b_r};

`ifdef MULT_DIV_SIGNED_DIV_EN
  assign div_a = sgn_r ? {2'b00, magnitude(a_r)} : {2'b00, a_r};
  assign div_b = sgn_r ? {2'b00, magnitude(b_r)} : {2'b00, b_r};
`else
  assign div_a = {2'b00, a_r};
  assign div_b = {2'b00, b_r};
`endif

  mult_div_booth_enc u_booth (
    .group ({bus.product_low, booth_prev}),
    .zero  (b_zero),
    .neg   (b_neg),
    .two   (b_two)
  );

  // State, counters and operands captured on an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      qbit       <= 1'b0;
      booth_prev <= 1'b0;
      op_r       <= 1'b0;
      sgn_r      <= 1'b0;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      neg_quot_r <= 1'b0;
      neg_rem_r  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      qbit       <= qbit_nx;
      booth_prev <= booth_prev_nx;
      if (state == IDLE && bus.start) begin
        op_r  <= bus.op;
        sgn_r <= bus.signed_op;
        a_r   <= bus.operand_a;
        b_r   <= bus.operand_b;
`ifdef MULT_DIV_SIGNED_DIV_EN
        neg_quot_r <= ~bus.op & bus.signed_op & (bus.operand_a[31] ^ bus.operand_b[31]);
        neg_rem_r  <= ~bus.op & bus.signed_op & bus.operand_a[31];
`else
        neg_quot_r <= 1'b0;
        neg_rem_r  <= 1'b0;
`endif
      end
    end
  end

  // Adder operand selection: Booth multiple in MUL, negated divisor in DSUB
  always_comb begin
    mag    = b_two ? {ext_b[32:0], 1'b0} : ext_b;
    addend = 34'd0;
    cin    = 1'b0;
    case (state)
      MUL: begin
        if (b_zero) begin
          addend = 34'd0;
        end else if (b_neg) begin
          addend = ~mag;
          cin    = 1'b1;
        end else begin
          addend = mag;
        end
      end
      DSUB: begin
        addend = ~div_b;
        cin    = 1'b1;
      end
      default: addend = 34'd0;
    endcase
  end

  assign sum = bus.product_top + addend + {33'd0, cin};

  // Next-state and register control decode
  always_comb begin
    state_nx               = state;
    cnt_nx                 = cnt;
    qbit_nx                = qbit;
    booth_prev_nx          = booth_prev;
    bus.init_we            = 1'b0;
    bus.we                 = 1'b0;
    bus.we_sub             = 1'b0;
    bus.shift              = 1'b0;
    bus.shift_type         = SHIFT_RIGHT2;
    bus.multiplier_dividen = 34'd0;
    bus.busy               = 1'b0;
    bus.done               = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nx = LOAD;
        else           state_nx = IDLE;
      end
      LOAD: begin
        bus.busy               = 1'b1;
        bus.init_we            = 1'b1;
        bus.multiplier_dividen = op_r ? ext_a : div_a;
        cnt_nx                 = 6'd0;
        booth_prev_nx          = 1'b0;
        qbit_nx                = 1'b0;
        state_nx               = op_r ? MUL : DPRE;
      end
      MUL: begin
        bus.busy      = 1'b1;
        bus.we        = 1'b1;
        bus.shift     = 1'b1;
        booth_prev_nx = bus.product_low[1];
        if (cnt == 6'(MUL_ITERS - 1)) begin
          cnt_nx   = 6'd0;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 6'd1;
        end
      end
      DPRE: begin
        bus.busy       = 1'b1;
        bus.we         = 1'b1;
        bus.shift      = 1'b1;
        bus.shift_type = SHIFT_LEFT0;
        if (cnt == 6'(DIV_PRESHIFT - 1)) begin
          cnt_nx   = 6'd0;
          state_nx = DSUB;
        end else begin
          cnt_nx = cnt + 6'd1;
        end
      end
      DSUB: begin
        bus.busy = 1'b1;
        // A clear sign bit means the divisor fits: keep the difference
        if (!sum[33]) begin
          bus.we     = 1'b1;
          bus.we_sub = 1'b1;
          qbit_nx    = 1'b1;
        end else begin
          qbit_nx = 1'b0;
        end
        state_nx = DSHF;
      end
      DSHF: begin
        bus.busy       = 1'b1;
        bus.we         = 1'b1;
        bus.shift      = 1'b1;
        bus.shift_type = qbit ? SHIFT_LEFT1 : SHIFT_LEFT0;
        if (cnt == 6'(DIV_ITERS - 1)) begin
          cnt_nx   = 6'd0;
          state_nx = DONE;
        end else begin
          cnt_nx   = cnt + 6'd1;
          state_nx = DSUB;
        end
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.result_of_add = sum;
  assign bus.neg_quot      = neg_quot_r;
  assign bus.neg_rem       = neg_rem_r;

endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq with a behavioural 68-bit result register and a
// scoreboard of expected products / quotients.
module tb_mult_div_seq;
  import mult_div_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_div_seq_if ifc ();

  mult_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [67:0] rreg;
  assign ifc.product_top = rreg[67:34];
  assign ifc.product_low = rreg[1:0];

  int checks = 0;
  int failures = 0;
  int right2_cnt = 0;
  int overlap_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    bit          op;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    bit          nq;
    bit          nr;
  } exp_t;

  exp_t sb[$];

  // Downstream result register
  always @(posedge clk) begin
    if (ifc.init_we) rreg <= {34'd0, ifc.multiplier_dividen};
    else if (ifc.we && ifc.we_sub) rreg[67:34] <= ifc.result_of_add;
    else if (ifc.we && ifc.shift) begin
      case (ifc.shift_type)
        SHIFT_RIGHT2:       rreg <= 68'($signed({ifc.result_of_add, rreg[33:0]}) >>> 2);
        SHIFT_LEFT_RESTORE: rreg <= {rreg[66:0], 1'b0};
        SHIFT_LEFT0:        rreg <= {rreg[66:0], 1'b0};
        SHIFT_LEFT1:        rreg <= {rreg[66:0], 1'b1};
        default:            rreg <= rreg;
      endcase
    end
  end

  // Control activity monitor
  always @(posedge clk) begin
    if (!rst) begin
      if (ifc.we && ifc.shift && ifc.shift_type == SHIFT_RIGHT2) right2_cnt <= right2_cnt + 1;
      if (ifc.shift && ifc.we_sub) overlap_cnt <= overlap_cnt + 1;
      if (ifc.done) done_cnt <= done_cnt + 1;
    end
  end

  function automatic exp_t make_exp(input bit op, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa, sbv;
    logic [31:0] ua, ub;
    bit sd;
`ifdef MULT_DIV_SIGNED_DIV_EN
    sd = sgn;
`else
    sd = 1'b0;
`endif
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    e.op   = op;
    e.prod = sgn ? 64'(sa * sbv) : ({32'd0, a} * {32'd0, b});
    ua = (sd && a[31]) ? -a : a;
    ub = (sd && b[31]) ? -b : b;
    e.quo = (ub == 32'd0) ? 32'hFFFF_FFFF : ua / ub;
    e.rem = (ub == 32'd0) ? ua : ua % ub;
    e.nq  = !op && sd && (a[31] ^ b[31]);
    e.nr  = !op && sd && a[31];
    return e;
  endfunction

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input bit op, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int exp_done, input int glitch);
    exp_t e;
    int edges = 0;
    bit got = 1'b0;
    int r0;
    sb.push_back(make_exp(op, sgn, a, b));
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = op; ifc.signed_op = sgn;
    ifc.operand_a = a; ifc.operand_b = b;
    @(posedge clk);
    r0 = right2_cnt;
    @(negedge clk);
    ifc.start = 1'b0; ifc.op = ~op; ifc.signed_op = ~sgn;
    ifc.operand_a = 32'h0BAD_F00D; ifc.operand_b = 32'h1234_5678;
    check("load_ctrl", {ifc.busy, ifc.init_we, ifc.we, ifc.shift, ifc.done}, 5'b11000);
    while (!got && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      ifc.start = (edges == glitch);
      if (ifc.done) got = 1'b1;
    end
    ifc.start = 1'b0;
    check("done_seen", got, 1'b1);
    check("done_edge", edges, exp_done);
    e = sb.pop_front();
    if (e.op) begin
      check("product", rreg[63:0], e.prod);
      check("right2_shifts", right2_cnt - r0, MUL_ITERS_DEFAULT);
    end else begin
      check("quotient", rreg[31:0], e.quo);
      check("remainder", rreg[66:35], e.rem);
      check("right2_in_div", right2_cnt - r0, 0);
    end
    check("neg_quot", ifc.neg_quot, e.nq);
    check("neg_rem", ifc.neg_rem, e.nr);
    @(posedge clk);
    @(negedge clk);
    check("idle_after", {ifc.busy, ifc.done}, 2'b00);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    ifc.start = 1'b0; ifc.op = 1'b0; ifc.signed_op = 1'b0;
    ifc.operand_a = 32'd0; ifc.operand_b = 32'd0;
    #1;
    check("reset_ctrl", {ifc.init_we, ifc.we, ifc.we_sub, ifc.shift, ifc.shift_type,
                         ifc.busy, ifc.done, ifc.neg_quot, ifc.neg_rem, ifc.multiplier_dividen}, 68'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(1'b1, 1'b0, 32'd7, 32'd6, 18, 0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, 18, 0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 18, 0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 3);
    run_op(1'b0, 1'b0, 32'd100, 32'd7, 68, 0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 68, 0);
    run_op(1'b0, 1'b0, 32'd5, 32'd0, 68, 0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 68, 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = 1'b1; ifc.signed_op = 1'b0;
    ifc.operand_a = 32'd9; ifc.operand_b = 32'd11;
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("rst_mid_ctrl", {ifc.init_we, ifc.we, ifc.we_sub, ifc.shift, ifc.shift_type,
                           ifc.busy, ifc.done, ifc.neg_quot, ifc.neg_rem, ifc.multiplier_dividen}, 68'd0);
    check("rst_mid_roa", ifc.result_of_add, ifc.product_top);
    check("rst_mid_state", dut.state, IDLE);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);
    run_op(1'b1, 1'b0, 32'd9, 32'd11, 18, 0);

    check("shift_we_sub_overlap", overlap_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
